// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage multiply/divide sequencer.
// Holds the FSM state encoding, the op codes and the divide-by-zero LO value.
package muldiv_pkg;

    localparam int ITER_CNT = 32;
    localparam logic [ITER_CNT-1:0] DIV0_LO = {ITER_CNT{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic {
        CLS_MUL = 1'b0,
        CLS_DIV = 1'b1
    } op_class_e;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// Pipeline-side handshake and result bus of the multiply/divide sequencer.
// master = EX stage driving operands, slave = the sequencer itself.
interface ex_muldiv_ctrl_if #(
    parameter int INST_SZ = 32
);
    logic               i_start_MC;
    logic [1:0]         i_op_MC;
    logic [INST_SZ-1:0] i_operand_a_E;
    logic [INST_SZ-1:0] i_operand_b_E;
    logic               i_mthi_MC;
    logic               i_mtlo_MC;
    logic [INST_SZ-1:0] i_wdata_E;
    logic               i_flush;
    logic               o_stall_E;
    logic [INST_SZ-1:0] o_hi;
    logic [INST_SZ-1:0] o_lo;
    logic               o_done;
    logic               o_div_zero;

    modport master (
        output i_start_MC, i_op_MC, i_operand_a_E, i_operand_b_E,
        output i_mthi_MC, i_mtlo_MC, i_wdata_E, i_flush,
        input  o_stall_E, o_hi, o_lo, o_done, o_div_zero
    );

    modport slave (
        input  i_start_MC, i_op_MC, i_operand_a_E, i_operand_b_E,
        input  i_mthi_MC, i_mtlo_MC, i_wdata_E, i_flush,
        output o_stall_E, o_hi, o_lo, o_done, o_div_zero
    );
endinterface

// File: rtl/muldiv_iter_step.sv
// One iteration of shift-add multiply or restoring divide, purely combinational.
// Multiply: {acc,q} shifts right, product bits enter q; divide: {acc,q} shifts left.
module muldiv_iter_step
    import muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  op_class_e    op_class,
    input  logic [W-1:0] acc,
    input  logic [W-1:0] q,
    input  logic [W-1:0] operand,
    output logic [W-1:0] acc_nxt,
    output logic [W-1:0] q_nxt
);
    logic [W:0] sum_s;
    logic [W:0] rem_sh_s;

    // Single multiply or divide step selected by the op class
    always_comb begin
        sum_s    = '0;
        rem_sh_s = '0;
        acc_nxt  = acc;
        q_nxt    = q;
        case (op_class)
            CLS_MUL: begin
                if (q[0]) begin
                    sum_s = {1'b0, acc} + {1'b0, operand};
                end else begin
                    sum_s = {1'b0, acc};
                end
                acc_nxt = sum_s[W:1];
                q_nxt   = {sum_s[0], q[W-1:1]};
            end
            CLS_DIV: begin
                // acc < divisor holds throughout, so the difference always fits W bits
                rem_sh_s = {acc, q[W-1]};
                if (rem_sh_s >= {1'b0, operand}) begin
                    acc_nxt = W'(rem_sh_s - {1'b0, operand});
                    q_nxt   = {q[W-2:0], 1'b1};
                end else begin
                    acc_nxt = rem_sh_s[W-1:0];
                    q_nxt   = {q[W-2:0], 1'b0};
                end
            end
            default: begin
                acc_nxt = acc;
                q_nxt   = q;
            end
        endcase
    end
endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage MULT/MULTU/DIV/DIVU sequencer owning HI/LO and the pipeline stall.
// Optional MULDIV_EARLY_EXIT_EN: multiply leaves CALC once the remaining multiplier is zero.
module ex_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int INST_SZ = ITER_CNT,
    parameter int CNT_SZ  = 6
) (
    input logic             i_clk,
    input logic             i_rst_n,
    ex_muldiv_ctrl_if.slave bus
);
    state_e               state_r, state_nxt_s;
    op_e                  op_r;
    logic [INST_SZ-1:0]   opa_r, opb_r, mcand_r, acc_r, q_r, hi_r, lo_r;
    logic [CNT_SZ-1:0]    cnt_r;
    logic                 sa_r, sb_r, div0_r, done_r, dz_r;
    logic                 stall_s, is_div_s, signed_s, early_s, neg_s;
    logic [INST_SZ-1:0]   abs_a_s, abs_b_s, acc_nxt_s, q_nxt_s, hi_res_s, lo_res_s;
    logic [2*INST_SZ-1:0] prod_u_s, prod_s;

    assign is_div_s = op_is_div(op_r);
    assign signed_s = op_is_signed(op_r);
    assign abs_a_s  = (signed_s && opa_r[INST_SZ-1]) ? (-opa_r) : opa_r;
    assign abs_b_s  = (signed_s && opb_r[INST_SZ-1]) ? (-opb_r) : opb_r;

    muldiv_iter_step #(.W(INST_SZ)) u_step (
        .op_class (is_div_s ? CLS_DIV : CLS_MUL),
        .acc      (acc_r),
        .q        (q_r),
        .operand  (mcand_r),
        .acc_nxt  (acc_nxt_s),
        .q_nxt    (q_nxt_s)
    );

`ifdef MULDIV_EARLY_EXIT_EN
    logic [INST_SZ-1:0] mplier_mask_s;
    // Low (cnt-1) bits of q after this step are the multiplier bits still to consume
    assign mplier_mask_s = ~({INST_SZ{1'b1}} << (cnt_r - CNT_SZ'(1)));
    assign early_s       = !is_div_s && ((q_nxt_s & mplier_mask_s) == '0);
    assign prod_u_s      = {acc_r, q_r} >> cnt_r;
`else
    assign early_s  = 1'b0;
    assign prod_u_s = {acc_r, q_r};
`endif

    // Sign correction and result selection for the commit cycle
    always_comb begin
        neg_s  = sa_r ^ sb_r;
        prod_s = neg_s ? (-prod_u_s) : prod_u_s;
        if (div0_r) begin
            hi_res_s = opa_r;
            lo_res_s = INST_SZ'(DIV0_LO);
        end else if (is_div_s) begin
            hi_res_s = sa_r ? (-acc_r) : acc_r;
            lo_res_s = neg_s ? (-q_r) : q_r;
        end else begin
            hi_res_s = prod_s[2*INST_SZ-1:INST_SZ];
            lo_res_s = prod_s[INST_SZ-1:0];
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and combinational stall
    always_comb begin
        state_nxt_s = state_r;
        stall_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_start_MC) begin
                    stall_s     = 1'b1;
                    state_nxt_s = ST_PREP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PREP: begin
                stall_s = 1'b1;
                if (bus.i_flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (is_div_s && (opb_r == '0)) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_CALC: begin
                stall_s = 1'b1;
                if (bus.i_flush) begin
                    state_nxt_s = ST_IDLE;
                end else if ((cnt_r == CNT_SZ'(1)) || early_s) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_FIX: begin
                stall_s = 1'b1;
                if (bus.i_flush) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath, HI/LO and completion pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_r    <= OP_MULT;
            opa_r   <= '0;
            opb_r   <= '0;
            mcand_r <= '0;
            acc_r   <= '0;
            q_r     <= '0;
            cnt_r   <= '0;
            sa_r    <= 1'b0;
            sb_r    <= 1'b0;
            div0_r  <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
            done_r  <= 1'b0;
            dz_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.i_start_MC) begin
                        op_r  <= op_e'(bus.i_op_MC);
                        opa_r <= bus.i_operand_a_E;
                        opb_r <= bus.i_operand_b_E;
                    end else begin
                        if (bus.i_mthi_MC) hi_r <= bus.i_wdata_E;
                        if (bus.i_mtlo_MC) lo_r <= bus.i_wdata_E;
                    end
                end
                ST_PREP: begin
                    sa_r    <= signed_s && opa_r[INST_SZ-1];
                    sb_r    <= signed_s && opb_r[INST_SZ-1];
                    div0_r  <= is_div_s && (opb_r == '0);
                    acc_r   <= '0;
                    cnt_r   <= CNT_SZ'(INST_SZ);
                    mcand_r <= is_div_s ? abs_b_s : abs_a_s;
                    q_r     <= is_div_s ? abs_a_s : abs_b_s;
                end
                ST_CALC: begin
                    acc_r <= acc_nxt_s;
                    q_r   <= q_nxt_s;
                    cnt_r <= cnt_r - CNT_SZ'(1);
                end
                ST_FIX: begin
                    if (!bus.i_flush) begin
                        hi_r <= hi_res_s;
                        lo_r <= lo_res_s;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
            done_r <= (state_r == ST_FIX) && !bus.i_flush;
            dz_r   <= (state_r == ST_FIX) && !bus.i_flush && div0_r;
        end
    end

    assign bus.o_stall_E  = stall_s;
    assign bus.o_hi       = hi_r;
    assign bus.o_lo       = lo_r;
    assign bus.o_done     = done_r;
    assign bus.o_div_zero = dz_r;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: directed vector table, corner sequences,
// and random ops against a plain-arithmetic reference model.
module tb_ex_muldiv_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    ex_muldiv_ctrl_if #(.INST_SZ(32)) bus ();

    ex_muldiv_ctrl #(.INST_SZ(32), .CNT_SZ(6)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: results from wide integer arithmetic, latency from the op rules
    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo,
                                      output logic dz, output int stalls);
        longint      la, lb, qq, rr;
        logic [63:0] p, uq, ur;
        logic [31:0] mag;
        int          len;
        dz = 1'b0;
        stalls = 35;
        hi = '0;
        lo = '0;
        if (op[1] == 1'b0) begin
            if (op == 2'b00) begin
                la = longint'($signed(a));
                lb = longint'($signed(b));
                p  = la * lb;
            end else begin
                p = 64'(a) * 64'(b);
            end
            hi = p[63:32];
            lo = p[31:0];
`ifdef MULDIV_EARLY_EXIT_EN
            mag = (op == 2'b00 && b[31]) ? (32'd0 - b) : b;
            len = 1;
            for (int i = 0; i < 32; i++) if (mag[i]) len = i + 1;
            stalls = 3 + len;
`else
            mag = b;
            len = 32;
            stalls = 3 + len;
`endif
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
            dz = 1'b1;
            stalls = 3;
        end else if (op == 2'b10) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            qq = la / lb;
            rr = la % lb;
            lo = qq[31:0];
            hi = rr[31:0];
        end else begin
            uq = 64'(a) / 64'(b);
            ur = 64'(a) % 64'(b);
            lo = uq[31:0];
            hi = ur[31:0];
        end
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int mtlo_cyc,
                          output logic [31:0] hi, output logic [31:0] lo, output logic dz,
                          output int stalls, output int dones, output int post_busy);
        bit seen;
        seen = 1'b0;
        stalls = 0; dones = 0; post_busy = 0; dz = 1'b0; hi = '0; lo = '0;
        @(negedge clk);
        bus.i_start_MC    = 1'b1;
        bus.i_op_MC       = op;
        bus.i_operand_a_E = a;
        bus.i_operand_b_E = b;
        for (int c = 0; c < 64 && !seen; c++) begin
            bus.i_mtlo_MC = (mtlo_cyc >= 0 && c >= mtlo_cyc && c < mtlo_cyc + 4);
            #1;
            if (bus.o_stall_E) stalls++;
            if (bus.o_done) begin
                seen = 1'b1;
                dones++;
                dz = bus.o_div_zero;
                hi = bus.o_hi;
                lo = bus.o_lo;
            end
            @(negedge clk);
        end
        // start was held through the DONE cycle; the instruction leaves EX now
        bus.i_start_MC = 1'b0;
        bus.i_mtlo_MC  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (bus.o_stall_E) post_busy++;
            if (bus.o_done) dones++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz, input int mtlo_cyc);
        logic [31:0] hi, lo, mhi, mlo;
        logic        dz, mdz;
        int          st, dn, pb, est;
        ref_model(op, a, b, mhi, mlo, mdz, est);
        run_op(op, a, b, mtlo_cyc, hi, lo, dz, st, dn, pb);
        check({tag, " hi"}, 64'(hi), 64'(ehi));
        check({tag, " lo"}, 64'(lo), 64'(elo));
        check({tag, " div_zero"}, 64'(dz), 64'(edz));
        check({tag, " stall_cycles"}, 64'(st), 64'(est));
        check({tag, " done_pulses"}, 64'(dn), 64'd1);
        check({tag, " post_stall"}, 64'(pb), 64'd0);
    endtask

    initial begin
        logic [31:0] rhi, rlo, ra, rb;
        logic        rdz;
        logic [1:0]  rop;
        int          rst_cnt, dn;

        vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[4]  = '{2'b10, 32'h0000_0055, 32'h0000_0000, 32'h0000_0055, 32'hFFFF_FFFF, 1'b1};
        vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[6]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[7]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[8]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0};
        vecs[9]  = '{2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
        vecs[10] = '{2'b01, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 32'h0000_000F, 1'b0};

        rst_n = 1'b0;
        bus.i_start_MC = 1'b0; bus.i_op_MC = 2'b00;
        bus.i_operand_a_E = '0; bus.i_operand_b_E = '0;
        bus.i_mthi_MC = 1'b0; bus.i_mtlo_MC = 1'b0;
        bus.i_wdata_E = '0; bus.i_flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset hi", 64'(bus.o_hi), 64'd0);
        check("reset lo", 64'(bus.o_lo), 64'd0);
        check("reset stall", 64'(bus.o_stall_E), 64'd0);
        check("reset done", 64'(bus.o_done), 64'd0);
        check("reset div_zero", 64'(bus.o_div_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // MTHI alone, then MTHI+MTLO together
        @(negedge clk);
        bus.i_mthi_MC = 1'b1; bus.i_wdata_E = 32'h0000_1234;
        @(negedge clk);
        bus.i_mthi_MC = 1'b0;
        #1;
        check("mthi hi", 64'(bus.o_hi), 64'h1234);
        check("mthi lo_untouched", 64'(bus.o_lo), 64'd0);
        @(negedge clk);
        bus.i_mthi_MC = 1'b1; bus.i_mtlo_MC = 1'b1; bus.i_wdata_E = 32'h0000_0077;
        @(negedge clk);
        bus.i_mthi_MC = 1'b0; bus.i_mtlo_MC = 1'b0;
        #1;
        check("mthilo hi", 64'(bus.o_hi), 64'h77);
        check("mthilo lo", 64'(bus.o_lo), 64'h77);

        for (int i = 0; i < 11; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].hi, vecs[i].lo, vecs[i].dz, -1);
        end

        // MTLO presented mid-CALC must be dropped
        bus.i_wdata_E = 32'h0000_DEAD;
        do_op("mtlo_in_calc", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 4);

        // Flush at CALC cycle 10 with HI/LO preloaded
        @(negedge clk);
        bus.i_mthi_MC = 1'b1; bus.i_wdata_E = 32'h0000_000A;
        @(negedge clk);
        bus.i_mthi_MC = 1'b0; bus.i_mtlo_MC = 1'b1; bus.i_wdata_E = 32'h0000_000B;
        @(negedge clk);
        bus.i_mtlo_MC = 1'b0;
        bus.i_start_MC = 1'b1; bus.i_op_MC = 2'b01;
        bus.i_operand_a_E = 32'hFFFF_FFFF; bus.i_operand_b_E = 32'hFFFF_FFFF;
        repeat (11) @(negedge clk);
        #1;
        check("flush pre_stall", 64'(bus.o_stall_E), 64'd1);
        bus.i_flush = 1'b1; bus.i_start_MC = 1'b0;
        @(negedge clk);
        bus.i_flush = 1'b0;
        #1;
        check("flush stall_released", 64'(bus.o_stall_E), 64'd0);
        check("flush hi", 64'(bus.o_hi), 64'hA);
        check("flush lo", 64'(bus.o_lo), 64'hB);
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (bus.o_done) dn++;
        end
        check("flush no_done", 64'(dn), 64'd0);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        bus.i_start_MC = 1'b1; bus.i_op_MC = 2'b11;
        bus.i_operand_a_E = 32'd1000; bus.i_operand_b_E = 32'd3;
        repeat (8) @(negedge clk);
        bus.i_start_MC = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst hi", 64'(bus.o_hi), 64'd0);
        check("midrst lo", 64'(bus.o_lo), 64'd0);
        check("midrst stall", 64'(bus.o_stall_E), 64'd0);
        check("midrst done", 64'(bus.o_done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (bus.o_done || bus.o_stall_E) dn++;
        end
        check("midrst quiet", 64'(dn), 64'd0);

        // Random ops against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            rst_cnt = $urandom_range(0, 7);
            if (rst_cnt == 0) rb = 32'd0;
            else if (rst_cnt < 3) rb = 32'($urandom_range(0, 300));
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000));
            ref_model(rop, ra, rb, rhi, rlo, rdz, dn);
            do_op($sformatf("rnd%0d", i), rop, ra, rb, rhi, rlo, rdz, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
